hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 46 ++++
 rtl/hazard_control_unit.sv | 135 +++++++++++++
 tb/tb_hazard_control_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- constants, FSM encoding and helpers shared by the hazard
// control logic.
//   CNT_W / CNT_MAX : performance counter width and saturation value
//   state_e         : control FSM state (RUN = 0, STALL = 1)
//   sat_inc()       : saturating counter increment
package pipeline_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect -- works out how many bubbles the instruction in ID needs.
//   i_id_rs1/2, i_id_uses_rs1/2 : sources read by the ID instruction
//   i_ex_rd, i_ex_memRead, i_ex_regWrite : producer in ID/EX
//   i_mem_rd, i_mem_regWrite    : producer in EX/MEM
//   i_fwd_en                    : forwarding network active
//   o_bubbles                   : 0..2 bubbles required
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_memRead,
  input  logic       i_ex_regWrite,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_regWrite,
  input  logic       i_fwd_en,
  output logic [1:0] o_bubbles
);

  logic w_ex_match;
  logic w_mem_match;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  assign w_ex_match  = (i_ex_rd != 5'd0) &&
                       ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                        (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));
  assign w_mem_match = (i_mem_rd != 5'd0) &&
                       ((i_id_uses_rs1 && (i_id_rs1 == i_mem_rd)) ||
                        (i_id_uses_rs2 && (i_id_rs2 == i_mem_rd)));

  always_comb begin
    o_bubbles = 2'd0;
    if (i_fwd_en) begin
      // With forwarding only a load feeding the next instruction costs a bubble.
      if (i_ex_memRead && w_ex_match) o_bubbles = 2'd1;
    end else begin
      // Without forwarding wait until the producer has written the regfile.
      if (i_ex_regWrite && w_ex_match)        o_bubbles = 2'd2;
      else if (i_mem_regWrite && w_mem_match) o_bubbles = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit -- pipeline stall / flush / freeze control.
//   clk, reset (sync, active high)
//   id_*  : ID instruction sources; ex_*, mem_* : producers in ID/EX, EX/MEM
//   mem_branch_taken, mem_busy, fwd_en : control inputs
//   pc_write, if_id_write : advance enables
//   if_id_flush, id_ex_flush, ex_mem_flush : zero control bits next edge
//   pipe_freeze : hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles, flush_count, freeze_cycles : saturating perf counters
// Priority: reset > mem_busy > branch taken > hazard stall > run.
module hazard_control_unit
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_regWrite,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regWrite,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  input  logic             fwd_en,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles
);

  state_e           r_state;
  logic [1:0]       r_stall_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic [CNT_W-1:0] r_freeze_cycles;

  state_e     w_state_nxt;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_bubbles;
  logic       w_stall;
  logic       w_flush;
  logic       w_freeze;

  hazard_detect u_hazard_detect (
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_uses_rs1  (id_uses_rs1),
    .i_id_uses_rs2  (id_uses_rs2),
    .i_ex_rd        (ex_rd),
    .i_ex_memRead   (ex_memRead),
    .i_ex_regWrite  (ex_regWrite),
    .i_mem_rd       (mem_rd),
    .i_mem_regWrite (mem_regWrite),
    .i_fwd_en       (fwd_en),
    .o_bubbles      (w_bubbles)
  );

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_freeze  = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_stall_cnt;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    w_freeze     = 1'b0;
    if (reset) begin
      // Hold fetch and scrub every pipeline register while in reset.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mem_busy) begin
      // Freeze wins over a pending redirect; the branch is replayed later.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
      w_freeze    = 1'b1;
    end else if (mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      w_state_nxt  = ST_RUN;
      w_cnt_nxt    = 2'd0;
      w_flush      = 1'b1;
    end else if (r_state == ST_STALL) begin
      // Remaining bubbles were decided on entry; hazards are not re-evaluated.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      w_stall     = 1'b1;
      w_cnt_nxt   = (r_stall_cnt != 2'd0) ? r_stall_cnt - 2'd1 : 2'd0;
      w_state_nxt = (r_stall_cnt <= 2'd1) ? ST_RUN : ST_STALL;
    end else if (w_bubbles != 2'd0) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      w_stall     = 1'b1;
      w_cnt_nxt   = w_bubbles - 2'd1;
      w_state_nxt = (w_bubbles > 2'd1) ? ST_STALL : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_RUN;
      r_stall_cnt     <= 2'd0;
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_freeze_cycles <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_stall_cnt     <= w_cnt_nxt;
      r_stall_cycles  <= sat_inc(r_stall_cycles, w_stall);
      r_flush_count   <= sat_inc(r_flush_count, w_flush);
      r_freeze_cycles <= sat_inc(r_freeze_cycles, w_freeze);
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign flush_count   = r_flush_count;
  assign freeze_cycles = r_freeze_cycles;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_memRead, ex_regWrite, mem_regWrite;
  logic        mem_branch_taken, mem_busy, fwd_en;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze;
  logic [31:0] stall_cycles, flush_count, freeze_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
    .mem_rd(mem_rd), .mem_regWrite(mem_regWrite),
    .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy), .fwd_en(fwd_en),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pipe_freeze(pipe_freeze),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .freeze_cycles(freeze_cycles)
  );

  // Packed control outputs: {pc_write, if_id_write, if_id, id_ex, ex_mem flush, freeze}
  function automatic logic [5:0] ctl();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze};
  endfunction

  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_FLUSH = 6'b111110;
  localparam logic [5:0] C_FRZ   = 6'b000001;
  localparam logic [5:0] C_RST   = 6'b001110;

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_memRead = 0; ex_regWrite = 0;
    mem_rd = 0; mem_regWrite = 0;
    mem_branch_taken = 0; mem_busy = 0; fwd_en = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; mem_busy = 1; mem_branch_taken = 1; fwd_en = 1;
    ex_memRead = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    #1;
    checks++;
    if (ctl() !== C_RST) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", ctl(), C_RST); end
    @(negedge clk);
    checks++;
    if ({stall_cycles, flush_count, freeze_cycles} !== 96'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", stall_cycles, flush_count, freeze_cycles);
    end
    clear_inputs(); reset = 0;
    #1;
    checks++;
    if (ctl() !== C_RUN) begin errors++; $display("FAIL reset_then_run got=%b exp=%b", ctl(), C_RUN); end
  endtask

  task automatic test_load_use();
    pulse_reset();
    fwd_en = 1; ex_memRead = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #1;
    checks++;
    if (ctl() !== C_STALL) begin errors++; $display("FAIL load_use_stall got=%b exp=%b", ctl(), C_STALL); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl() !== C_RUN) begin errors++; $display("FAIL load_use_resume got=%b exp=%b", ctl(), C_RUN); end
    checks++;
    if (stall_cycles !== 32'd1) begin errors++; $display("FAIL load_use_count got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_no_forward();
    pulse_reset();
    fwd_en = 0; ex_regWrite = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    #1;
    checks++;
    if (ctl() !== C_STALL) begin errors++; $display("FAIL nofwd_stall1 got=%b exp=%b", ctl(), C_STALL); end
    @(negedge clk);
    clear_inputs();   // STALL must persist without the hazard inputs
    #1;
    checks++;
    if (ctl() !== C_STALL) begin errors++; $display("FAIL nofwd_stall2 got=%b exp=%b", ctl(), C_STALL); end
    @(negedge clk);
    #1;
    checks++;
    if (ctl() !== C_RUN) begin errors++; $display("FAIL nofwd_resume got=%b exp=%b", ctl(), C_RUN); end
    checks++;
    if (stall_cycles !== 32'd2) begin errors++; $display("FAIL nofwd_count got=%0d exp=2", stall_cycles); end
    ex_regWrite = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
    #1;
    checks++;
    if (ctl() !== C_RUN) begin errors++; $display("FAIL nofwd_x0 got=%b exp=%b", ctl(), C_RUN); end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd2) begin errors++; $display("FAIL nofwd_x0_count got=%0d exp=2", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_branch_mid_stall();
    pulse_reset();
    fwd_en = 0; ex_regWrite = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1;
    @(negedge clk);
    clear_inputs(); mem_branch_taken = 1;
    #1;
    checks++;
    if (ctl() !== C_FLUSH) begin errors++; $display("FAIL branch_flush got=%b exp=%b", ctl(), C_FLUSH); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl() !== C_RUN) begin errors++; $display("FAIL branch_run got=%b exp=%b", ctl(), C_RUN); end
    checks++;
    if (flush_count !== 32'd1 || stall_cycles !== 32'd1) begin
      errors++; $display("FAIL branch_counts got=%0d/%0d exp=1/1", flush_count, stall_cycles);
    end
  endtask

  task automatic test_busy_branch();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      mem_busy = 1; mem_branch_taken = 1;
      #1;
      checks++;
      if (ctl() !== C_FRZ) begin errors++; $display("FAIL busy_freeze%0d got=%b exp=%b", i, ctl(), C_FRZ); end
      @(negedge clk);
    end
    mem_busy = 0;
    #1;
    checks++;
    if (ctl() !== C_FLUSH) begin errors++; $display("FAIL busy_then_flush got=%b exp=%b", ctl(), C_FLUSH); end
    checks++;
    if (freeze_cycles !== 32'd3) begin errors++; $display("FAIL busy_count got=%0d exp=3", freeze_cycles); end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (flush_count !== 32'd1) begin errors++; $display("FAIL busy_flush_count got=%0d exp=1", flush_count); end
  endtask

  task automatic test_reset_mid_stall_sat();
    pulse_reset();
    fwd_en = 0; ex_regWrite = 1; ex_rd = 4; id_rs1 = 4; id_uses_rs1 = 1;
    @(negedge clk);          // now in STALL
    clear_inputs(); reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if (ctl() !== C_RUN) begin errors++; $display("FAIL rst_stall_run got=%b exp=%b", ctl(), C_RUN); end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall_count got=%0d exp=0", stall_cycles); end
    force dut.r_stall_cycles = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_stall_cycles;
    fwd_en = 1; ex_memRead = 1; ex_rd = 6; id_rs2 = 6; id_uses_rs2 = 1;
    #1;
    checks++;
    if (ctl() !== C_STALL) begin errors++; $display("FAIL sat_stall got=%b exp=%b", ctl(), C_STALL); end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_cycles); end
  endtask

  // Reference model: bubbles still owed plus event counts, updated per the rules.
  function automatic bit dep(bit uses, int rs, int rd);
    return uses && rd != 0 && rs == rd;
  endfunction

  function automatic int need_bubbles();
    bit ex_dep  = dep(id_uses_rs1, id_rs1, ex_rd)  || dep(id_uses_rs2, id_rs2, ex_rd);
    bit mem_dep = dep(id_uses_rs1, id_rs1, mem_rd) || dep(id_uses_rs2, id_rs2, mem_rd);
    if (fwd_en) return (ex_memRead && ex_dep) ? 1 : 0;
    if (ex_regWrite && ex_dep) return 2;
    if (mem_regWrite && mem_dep) return 1;
    return 0;
  endfunction

  task automatic test_random();
    int owed = 0;
    longint n_stall = 0, n_flush = 0, n_frz = 0;
    logic [5:0] exp_ctl;
    int kind, n;
    pulse_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      reset            = ($urandom_range(99) == 0);
      mem_busy         = ($urandom_range(7) == 0);
      mem_branch_taken = ($urandom_range(7) == 0);
      fwd_en           = $urandom_range(1);
      id_rs1 = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3));
      ex_rd  = 5'($urandom_range(3)); mem_rd = 5'($urandom_range(3));
      id_uses_rs1 = $urandom_range(1); id_uses_rs2 = $urandom_range(1);
      ex_memRead = $urandom_range(1); ex_regWrite = $urandom_range(1);
      mem_regWrite = $urandom_range(1);
      n = need_bubbles();
      if (reset)                 kind = 0;
      else if (mem_busy)         kind = 1;
      else if (mem_branch_taken) kind = 2;
      else if (owed > 0)         kind = 3;
      else if (n > 0)            kind = 4;
      else                       kind = 5;
      case (kind)
        0: exp_ctl = C_RST;
        1: exp_ctl = C_FRZ;
        2: exp_ctl = C_FLUSH;
        3, 4: exp_ctl = C_STALL;
        default: exp_ctl = C_RUN;
      endcase
      #1;
      checks++;
      if (ctl() !== exp_ctl) begin
        errors++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", cyc, ctl(), exp_ctl);
      end
      checks++;
      if (stall_cycles !== 32'(n_stall) || flush_count !== 32'(n_flush) || freeze_cycles !== 32'(n_frz)) begin
        errors++;
        $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc,
                 stall_cycles, flush_count, freeze_cycles, n_stall, n_flush, n_frz);
      end
      case (kind)
        0: begin owed = 0; n_stall = 0; n_flush = 0; n_frz = 0; end
        1: n_frz++;
        2: begin n_flush++; owed = 0; end
        3: begin n_stall++; owed--; end
        4: begin n_stall++; owed = n - 1; end
        default: ;
      endcase
      @(negedge clk);
    end
    clear_inputs(); reset = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_load_use();
    test_no_forward();
    test_branch_mid_stall();
    test_busy_branch();
    test_reset_mid_stall_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
